// File: rtl/costas_acq_ctrl_pkg.sv
// costas_pkg: shared types and constants for the Costas acquisition controller.
//   state_t      : controller FSM states
//   NOMINAL_PINC : nominal NCO phase increment that freq_offset is added to
//   W_IQ_DEF     : default I/Q sample width
//   metric_w()   : lock-metric accumulator width for a given sample width and window
package costas_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_STEP,
        ST_SETTLE,
        ST_MEASURE,
        ST_TRACK
    } state_t;

    localparam logic signed [31:0] NOMINAL_PINC = 32'sd919123001;
    localparam int W_IQ_DEF = 14;

    // |i|-|q| needs W_IQ+2 signed bits; summing 2^win_log2 of them adds win_log2 bits.
    function automatic int metric_w(input int w_iq, input int win_log2);
        return w_iq + 2 + win_log2;
    endfunction

endpackage

// File: rtl/costas_acq_ctrl_if.sv
// costas_acq_ctrl_if: controller <-> Costas loop datapath bundle.
//   iq_valid/i_data/q_data : loop I/Q low-pass outputs (datapath -> controller)
//   loop_rst/loop_en       : loop datapath reset / enable (controller -> datapath)
//   freq_offset            : signed offset added to NOMINAL_PINC
//   gain_sel               : 0 = wide acquisition gain, 1 = narrow track gain
// master = controller side, slave = datapath side.
interface costas_acq_ctrl_if #(
    parameter int W_IQ = costas_pkg::W_IQ_DEF
);
    logic                   iq_valid;
    logic signed [W_IQ-1:0] i_data;
    logic signed [W_IQ-1:0] q_data;
    logic                   loop_rst;
    logic                   loop_en;
    logic signed [31:0]     freq_offset;
    logic                   gain_sel;

    modport master (
        input  iq_valid, i_data, q_data,
        output loop_rst, loop_en, freq_offset, gain_sel
    );

    modport slave (
        output iq_valid, i_data, q_data,
        input  loop_rst, loop_en, freq_offset, gain_sel
    );
endinterface

// File: rtl/costas_acq_ctrl_lock_metric.sv
// costas_lock_metric: windowed lock metric sum(|i| - |q|) over 2^WIN_LOG2 valid samples.
//   clk, rst_n    : clock, async active-low reset
//   clear_i       : drop the partial window (sum and sample count)
//   en_i          : accumulate only while set
//   iq_valid_i    : qualifies i_data_i / q_data_i
//   i/q_data_i    : signed loop LPF outputs
//   win_done_o    : high in the cycle carrying the last sample of a window
//   acc_o         : running sum including the current cycle's sample; on
//                   win_done_o this is the complete window total
module costas_lock_metric
    import costas_pkg::*;
#(
    parameter  int W_IQ     = W_IQ_DEF,
    parameter  int WIN_LOG2 = 10,
    localparam int ACC_W    = metric_w(W_IQ, WIN_LOG2)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clear_i,
    input  logic                    en_i,
    input  logic                    iq_valid_i,
    input  logic signed [W_IQ-1:0]  i_data_i,
    input  logic signed [W_IQ-1:0]  q_data_i,
    output logic                    win_done_o,
    output logic signed [ACC_W-1:0] acc_o
);
    logic signed [W_IQ:0]   i_ext, q_ext, abs_i, abs_q;
    logic signed [W_IQ+1:0] diff;
    logic signed [ACC_W-1:0] acc_q;
    logic [WIN_LOG2-1:0]     cnt_q;
    logic                    take;

    // One extra bit so the most negative input has a representable magnitude.
    assign i_ext = {i_data_i[W_IQ-1], i_data_i};
    assign q_ext = {q_data_i[W_IQ-1], q_data_i};
    assign abs_i = i_ext[W_IQ] ? -i_ext : i_ext;
    assign abs_q = q_ext[W_IQ] ? -q_ext : q_ext;
    assign diff  = {1'b0, abs_i} - {1'b0, abs_q};

    assign take       = en_i && iq_valid_i;
    assign win_done_o = take && (cnt_q == '1);
    // Exposing the sum including this sample lets the FSM decide on the same edge.
    assign acc_o      = acc_q + (take ? {{WIN_LOG2{diff[W_IQ+1]}}, diff} : '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
            cnt_q <= '0;
        end else if (clear_i) begin
            acc_q <= '0;
            cnt_q <= '0;
        end else if (take) begin
            cnt_q <= cnt_q + WIN_LOG2'(1);
            acc_q <= win_done_o ? '0 : acc_o;
        end
    end
endmodule

// File: rtl/costas_acq_ctrl.sv
// costas_acq_ctrl: acquisition/lock controller for the Costas carrier-recovery loop.
// Sweeps freq_offset over [-SWEEP_SPAN, SWEEP_SPAN], resetting and settling the loop
// per step, measures a windowed |i|-|q| metric, locks into narrow tracking gain and
// re-acquires after LOSS_CNT consecutive bad tracking windows.
//   clk, rst_n  : clock, async active-low reset
//   start       : pulse, begin acquisition from IDLE
//   stop        : pulse, return to IDLE from any state (beats start)
//   bus         : loop datapath bundle (I/Q in; loop_rst, loop_en, freq_offset, gain_sel out)
//   locked      : lock indication
//   sweep_wraps : saturating count of full sweeps without lock
module costas_acq_ctrl
    import costas_pkg::*;
#(
    parameter int                 W_IQ       = W_IQ_DEF,
    parameter logic signed [31:0] SWEEP_SPAN = 32'sd8589934,
    parameter logic signed [31:0] SWEEP_STEP = 32'sd1073741,
    parameter int                 SETTLE     = 256,
    parameter int                 WIN_LOG2   = 10,
    parameter int                 LOCK_TH    = 400000,
    parameter int                 UNLOCK_TH  = 100000,
    parameter int                 LOSS_CNT   = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic                     stop,
    costas_acq_ctrl_if.master        bus,
    output logic                     locked,
    output logic [7:0]               sweep_wraps
);
    localparam int ACC_W = metric_w(W_IQ, WIN_LOG2);
    localparam int SET_W = $clog2(SETTLE + 1);
    localparam int BAD_W = $clog2(LOSS_CNT + 1);

    state_t             state_q;
    logic [SET_W-1:0]   settle_q;
    logic [BAD_W-1:0]   bad_q;
    logic               loop_rst_q, loop_en_q, gain_q, locked_q;
    logic signed [31:0] freq_q;
    logic [7:0]         wraps_q;

    logic                    win_done;
    logic signed [ACC_W-1:0] acc;
    logic signed [31:0]      acc_ext;
    logic signed [32:0]      next_off;

    costas_lock_metric #(.W_IQ(W_IQ), .WIN_LOG2(WIN_LOG2)) u_metric (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear_i    (state_q == ST_IDLE || state_q == ST_STEP),
        .en_i       (state_q == ST_MEASURE || state_q == ST_TRACK),
        .iq_valid_i (bus.iq_valid),
        .i_data_i   (bus.i_data),
        .q_data_i   (bus.q_data),
        .win_done_o (win_done),
        .acc_o      (acc)
    );

    // Thresholds may exceed the accumulator range for small windows; compare at 32 bits.
    assign acc_ext  = 32'(acc);
    // One guard bit so offset + step cannot wrap before the span check.
    assign next_off = 33'(freq_q) + 33'(SWEEP_STEP);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            settle_q   <= '0;
            bad_q      <= '0;
            loop_rst_q <= 1'b1;
            loop_en_q  <= 1'b0;
            freq_q     <= '0;
            gain_q     <= 1'b0;
            locked_q   <= 1'b0;
            wraps_q    <= '0;
        end else if (stop) begin
            state_q    <= ST_IDLE;
            loop_rst_q <= 1'b1;
            loop_en_q  <= 1'b0;
            freq_q     <= '0;
            gain_q     <= 1'b0;
            locked_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: if (start) begin
                    state_q <= ST_STEP;
                    freq_q  <= -SWEEP_SPAN;
                    wraps_q <= '0;
                end
                ST_STEP: begin
                    state_q    <= ST_SETTLE;
                    settle_q   <= '0;
                    loop_rst_q <= 1'b0;
                    loop_en_q  <= 1'b1;
                    gain_q     <= 1'b0;
                    locked_q   <= 1'b0;
                end
                ST_SETTLE: begin
                    if (settle_q == SET_W'(SETTLE - 1)) state_q <= ST_MEASURE;
                    else settle_q <= settle_q + SET_W'(1);
                end
                ST_MEASURE: if (win_done) begin
                    if (acc_ext > LOCK_TH) begin
                        state_q  <= ST_TRACK;
                        gain_q   <= 1'b1;
                        locked_q <= 1'b1;
                        bad_q    <= '0;
                    end else begin
                        state_q    <= ST_STEP;
                        loop_rst_q <= 1'b1;
                        loop_en_q  <= 1'b0;
                        if (next_off <= 33'(SWEEP_SPAN)) begin
                            freq_q <= next_off[31:0];
                        end else begin
                            freq_q <= -SWEEP_SPAN;
                            if (wraps_q != 8'hFF) wraps_q <= wraps_q + 8'd1;
                        end
                    end
                end
                ST_TRACK: if (win_done) begin
                    if (acc_ext < UNLOCK_TH) begin
                        if (bad_q == BAD_W'(LOSS_CNT - 1)) begin
                            state_q    <= ST_STEP;
                            loop_rst_q <= 1'b1;
                            loop_en_q  <= 1'b0;
                            gain_q     <= 1'b0;
                            locked_q   <= 1'b0;
                            freq_q     <= -SWEEP_SPAN;
                            bad_q      <= '0;
                        end else begin
                            bad_q <= bad_q + BAD_W'(1);
                        end
                    end else begin
                        bad_q <= '0;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.loop_rst    = loop_rst_q;
    assign bus.loop_en     = loop_en_q;
    assign bus.freq_offset = freq_q;
    assign bus.gain_sel    = gain_q;
    assign locked          = locked_q;
    assign sweep_wraps     = wraps_q;
endmodule

// File: tb/tb_costas_acq_ctrl.sv
// Directed-sequence bench with randomized I/Q samples, checked against a
// window-level model of the acquisition rules. A second, tiny-parameter
// instance exercises sweep_wraps saturation in a short run.
module tb_costas_acq_ctrl;
    localparam longint SPAN      = 8589934;
    localparam longint STEP      = 1073741;
    localparam int     SETTLE    = 256;
    localparam int     WIN       = 1024;
    localparam int     LOCK_TH   = 400000;
    localparam int     UNLOCK_TH = 100000;
    localparam int     LOSS      = 4;
    localparam int     K_GOOD = 0, K_ZERO = 1, K_BAD = 2, K_EXACT = 3;

    logic       clk = 1'b0, rst_n = 1'b0, start = 1'b0, stop = 1'b0;
    logic       start_b = 1'b0, stop_b = 1'b0;
    logic       locked, locked_b;
    logic [7:0] wraps, wraps_b;

    int     checks = 0, failures = 0, rst_falls = 0;
    logic   rst_prev = 1'b1;
    longint exp_off = 0;
    int     exp_wraps = 0, bad = 0;
    logic   exp_locked = 1'b0;

    costas_acq_ctrl_if #(.W_IQ(14)) bus_a ();
    costas_acq_ctrl_if #(.W_IQ(14)) bus_b ();

    always #5 clk = ~clk;

    costas_acq_ctrl #(.W_IQ(14)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
        .bus(bus_a), .locked(locked), .sweep_wraps(wraps)
    );

    costas_acq_ctrl #(
        .W_IQ(14), .SWEEP_SPAN(32'sd100), .SWEEP_STEP(32'sd200),
        .SETTLE(4), .WIN_LOG2(2)
    ) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .stop(stop_b),
        .bus(bus_b), .locked(locked_b), .sweep_wraps(wraps_b)
    );

    // Count loop_rst 1->0 transitions: one per STEP -> SETTLE.
    always @(negedge clk) begin
        if (rst_prev && !bus_a.loop_rst) rst_falls++;
        rst_prev = bus_a.loop_rst;
    end

    task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int iabs(input int x);
        return (x < 0) ? -x : x;
    endfunction

    task automatic tick(input logic v, input int i, input int q);
        bus_a.iq_valid = v;
        bus_a.i_data   = 14'(i);
        bus_a.q_data   = 14'(q);
        @(negedge clk);
    endtask

    task automatic gen(input int kind, output int i, output int q);
        case (kind)
            K_GOOD: begin
                i = ($urandom_range(0, 7) == 0) ? 8192 : int'($urandom_range(3000, 8191));
                q = $urandom_range(0, 1000);
            end
            K_ZERO: begin
                i = $urandom_range(0, 8191);
                q = i;
            end
            default: begin
                i = $urandom_range(0, 1000);
                q = $urandom_range(3000, 8191);
            end
        endcase
        if ($urandom_range(0, 1) == 1) i = -i;
        if ($urandom_range(0, 1) == 1) q = -q;
        if (i == 8192) i = -8192;   // only -8192 is representable
    endtask

    task automatic garbage();
        tick(1'b0, int'($urandom_range(0, 16383)) - 8192, int'($urandom_range(0, 16383)) - 8192);
    endtask

    // Drive one window of WIN valid samples; returns the true metric sum.
    task automatic window(input int kind, input int target, input int vpct,
                          input logic lk_before, output longint sum);
        int n, i, q;
        n = 0;
        sum = 0;
        while (n < WIN) begin
            if (int'($urandom_range(0, 99)) < vpct) begin
                if (kind == K_EXACT) begin
                    i = target / WIN + ((n < target % WIN) ? 1 : 0);
                    q = 0;
                end else begin
                    gen(kind, i, q);
                end
                sum += iabs(i) - iabs(q);
                n++;
                if (n == WIN) chk("pre_decision_locked", locked, lk_before);
                tick(1'b1, i, q);
            end else begin
                garbage();
            end
        end
        bus_a.iq_valid = 1'b0;
    endtask

    // One acquisition dwell, entered with the DUT in STEP.
    task automatic dwell(input int kind, input int target, input int vpct);
        longint s;
        chk("step_loop_rst", bus_a.loop_rst, 1);
        chk("step_freq", bus_a.freq_offset, exp_off);
        tick(1'b0, 0, 0);
        chk("settle_loop_en", bus_a.loop_en, 1);
        chk("settle_loop_rst", bus_a.loop_rst, 0);
        for (int k = 0; k < SETTLE; k++) begin
            start = (k == 10);   // start outside IDLE must be ignored
            if ($urandom_range(0, 1) == 1) tick(1'b1, 3000, -8000);
            else garbage();
        end
        start = 1'b0;
        window(kind, target, vpct, 1'b0, s);
        if (s > LOCK_TH) begin
            exp_locked = 1'b1;
            bad = 0;
        end else begin
            exp_locked = 1'b0;
            if (exp_off + STEP <= SPAN) exp_off += STEP;
            else begin
                exp_off = -SPAN;
                if (exp_wraps < 255) exp_wraps++;
            end
        end
        chk("dwell_locked", locked, exp_locked);
        chk("dwell_gain", bus_a.gain_sel, exp_locked);
        chk("dwell_loop_rst", bus_a.loop_rst, !exp_locked);
        chk("dwell_freq", bus_a.freq_offset, exp_off);
        chk("dwell_wraps", wraps, exp_wraps);
    endtask

    // One tracking window, entered with the DUT in TRACK.
    task automatic track_win(input int kind, input int target);
        longint s;
        window(kind, target, 90, 1'b1, s);
        if (s < UNLOCK_TH) bad++;
        else bad = 0;
        if (bad == LOSS) begin
            exp_locked = 1'b0;
            exp_off = -SPAN;
            bad = 0;
        end
        chk("track_locked", locked, exp_locked);
        chk("track_gain", bus_a.gain_sel, exp_locked);
        chk("track_freq", bus_a.freq_offset, exp_off);
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_loop_rst"}, bus_a.loop_rst, 1);
        chk({tag, "_loop_en"}, bus_a.loop_en, 0);
        chk({tag, "_freq"}, bus_a.freq_offset, 0);
        chk({tag, "_gain"}, bus_a.gain_sel, 0);
        chk({tag, "_locked"}, locked, 0);
    endtask

    task automatic do_start();
        start = 1'b1;
        tick(1'b0, 0, 0);
        start = 1'b0;
        exp_off = -SPAN;
        exp_wraps = 0;
        exp_locked = 1'b0;
        bad = 0;
    endtask

    initial begin
        int f0;
        bus_a.iq_valid = 1'b0; bus_a.i_data = '0; bus_a.q_data = '0;
        bus_b.iq_valid = 1'b1; bus_b.i_data = '0; bus_b.q_data = '0;

        // Reset and idle
        repeat (3) @(negedge clk);
        chk_idle("reset");
        chk("reset_wraps", wraps, 0);
        rst_n = 1'b1;
        repeat (20) garbage();
        chk_idle("idle");

        // start and stop together: stop wins
        start = 1'b1; stop = 1'b1;
        tick(1'b0, 0, 0);
        start = 1'b0; stop = 1'b0;
        chk("startstop_freq", bus_a.freq_offset, 0);
        tick(1'b0, 0, 0);
        chk_idle("startstop");

        // Immediate lock: i=+4000, q=0 every cycle, exact latency
        do_start();
        dwell(K_EXACT, 4000 * WIN, 100);
        chk("imm_loop_en", bus_a.loop_en, 1);

        // stop while tracking
        stop = 1'b1; tick(1'b0, 0, 0); stop = 1'b0;
        chk_idle("stop_track");

        // stop while measuring
        do_start();
        repeat (1 + SETTLE + 100) tick(1'b1, 5000, 0);
        chk("measure_loop_en", bus_a.loop_en, 1);
        stop = 1'b1; tick(1'b1, 5000, 0); stop = 1'b0;
        chk_idle("stop_measure");

        // Sweep then lock on the third dwell
        do_start();
        f0 = rst_falls;
        dwell(K_ZERO, 0, 90);
        dwell(K_ZERO, 0, 90);
        dwell(K_GOOD, 0, 90);
        chk("sweep_lock_freq", bus_a.freq_offset, -SPAN + 2 * STEP);
        chk("sweep_rst_pulses", rst_falls - f0, 3);
        chk("sweep_locked", locked, 1);

        // Threshold boundary, full sweep wrap, then lock just over threshold
        stop = 1'b1; tick(1'b0, 0, 0); stop = 1'b0;
        do_start();
        dwell(K_EXACT, LOCK_TH, 90);
        for (int d = 0; d < 15; d++) dwell(K_ZERO, 0, 90);
        chk("pre_wrap_freq", bus_a.freq_offset, -SPAN + 16 * STEP);
        dwell(K_ZERO, 0, 90);
        chk("wrap_freq", bus_a.freq_offset, -SPAN);
        chk("wrap_count", wraps, 1);
        dwell(K_EXACT, LOCK_TH + 1, 90);
        chk("edge_lock", locked, 1);

        // Loss of lock: 3 bad, 1 good (exactly UNLOCK_TH), 4 bad
        for (int w = 0; w < 3; w++) track_win(K_BAD, 0);
        track_win(K_EXACT, UNLOCK_TH);
        track_win(K_BAD, 0);
        track_win(K_BAD, 0);
        track_win(K_EXACT, UNLOCK_TH - 1);
        chk("loss_hold_locked", locked, 1);
        track_win(K_BAD, 0);
        chk("loss_locked", locked, 0);
        chk("loss_loop_rst", bus_a.loop_rst, 1);
        chk("loss_loop_en", bus_a.loop_en, 0);

        // Re-acquire, then async reset mid-track
        dwell(K_GOOD, 0, 90);
        chk("relock_wraps", wraps, 1);
        #2 rst_n = 1'b0;
        #1;
        chk_idle("async_rst");
        chk("async_rst_wraps", wraps, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) garbage();
        chk_idle("post_rst");

        // Saturation on the small instance: 2 dwells per sweep, 9 clk per dwell
        start_b = 1'b1; @(negedge clk); start_b = 1'b0;
        for (int d = 1; d <= 520; d++) begin
            repeat (9) @(negedge clk);
            if (d == 1) chk("sat_freq_d1", bus_b.freq_offset, 100);
            if (d == 2) begin
                chk("sat_freq_d2", bus_b.freq_offset, -100);
                chk("sat_wraps_d2", wraps_b, 1);
            end
            if (d == 510) chk("sat_wraps_510", wraps_b, 255);
        end
        chk("sat_wraps_end", wraps_b, 255);
        chk("sat_locked", locked_b, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
